// File: rtl/adpll_loop_seq_if.sv
// Programming bus from the loop sequencer to the ADPLL parameter registers.
interface adpll_loop_seq_if;
    logic       clr;
    logic       pgm;
    logic [2:0] param_sel;
    logic [4:0] pgm_value;

    modport master (output clr, output pgm, output param_sel, output pgm_value);
    modport slave  (input  clr, input  pgm, input  param_sel, input  pgm_value);
endinterface

// File: rtl/adpll_loop_seq.sv
// ADPLL programming and lock-supervision sequencer: clears and loads the parameter
// set, watches the filter magnitude for lock, and swaps acquisition/tracking gains.
module adpll_loop_seq #(
    parameter int unsigned LOCK_CNT   = 64,
    parameter int unsigned UNLOCK_CNT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [3:0]       ndiv_cfg,
    input  logic [4:0]       acq_alpha,
    input  logic [4:0]       acq_beta,
    input  logic [4:0]       trk_alpha,
    input  logic [4:0]       trk_beta,
    input  logic [4:0]       dco_offset_cfg,
    input  logic [4:0]       dco_thresh_cfg,
    input  logic [4:0]       kdco_cfg,
    input  logic [4:0]       lock_tol,
    input  logic [4:0]       filt_val,
    input  logic             filt_sign,
    adpll_loop_seq_if.master pgm_if,
    output logic             busy,
    output logic             locked,
    output logic [3:0]       relock_cnt
);

    localparam int unsigned RUN_W = 8;
    localparam logic [RUN_W-1:0] LOCK_LAST   = RUN_W'(LOCK_CNT - 1);
    localparam logic [RUN_W-1:0] UNLOCK_LAST = RUN_W'(UNLOCK_CNT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_LOAD_ACQ, S_ACQUIRE, S_LOAD_TRK, S_TRACK, S_LOAD_REACQ
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       beat_q, beat_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [3:0]       relock_q, relock_d;

    logic [3:0] ndiv_q, ndiv_d;
    logic [4:0] aa_q, aa_d, ab_q, ab_d, ta_q, ta_d, tb_q, tb_d;
    logic [4:0] off_q, off_d, thr_q, thr_d, kdco_q, kdco_d, tol_q, tol_d;

    logic       clr_q, clr_d, pgm_q, pgm_d, busy_q, busy_d, locked_q, locked_d;
    logic [2:0] sel_q, sel_d;
    logic [4:0] val_q, val_d;
    logic       in_tol;
    logic       unused_sign;

    // Sign of the filter output plays no part in the lock decision.
    assign unused_sign = filt_sign;
    assign in_tol      = (filt_val <= tol_q);

    // Next-state, run counter and shadow capture.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        run_d    = run_q;
        relock_d = relock_q;
        ndiv_d   = ndiv_q;
        aa_d     = aa_q;
        ab_d     = ab_q;
        ta_d     = ta_q;
        tb_d     = tb_q;
        off_d    = off_q;
        thr_d    = thr_q;
        kdco_d   = kdco_q;
        tol_d    = tol_q;

        if (abort) begin
            state_d = S_IDLE;
            beat_d  = 3'd0;
            run_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d  = S_CLEAR;
                        relock_d = 4'd0;
                        ndiv_d   = ndiv_cfg;
                        aa_d     = acq_alpha;
                        ab_d     = acq_beta;
                        ta_d     = trk_alpha;
                        tb_d     = trk_beta;
                        off_d    = dco_offset_cfg;
                        thr_d    = dco_thresh_cfg;
                        kdco_d   = kdco_cfg;
                        tol_d    = lock_tol;
                    end
                end
                S_CLEAR: begin
                    state_d = S_LOAD_ACQ;
                    beat_d  = 3'd0;
                end
                S_LOAD_ACQ: begin
                    if (beat_q == 3'd5) begin
                        state_d = S_ACQUIRE;
                        beat_d  = 3'd0;
                        run_d   = '0;
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
                end
                S_ACQUIRE: begin
                    if (!in_tol) begin
                        run_d = '0;
                    end else if (run_q == LOCK_LAST) begin
                        run_d   = '0;
                        state_d = S_LOAD_TRK;
                        beat_d  = 3'd0;
                    end else begin
                        run_d = run_q + RUN_W'(1);
                    end
                end
                S_LOAD_TRK: begin
                    if (beat_q == 3'd1) begin
                        state_d = S_TRACK;
                        beat_d  = 3'd0;
                        run_d   = '0;
                    end else begin
                        beat_d = 3'd1;
                    end
                end
                S_TRACK: begin
                    if (in_tol) begin
                        run_d = '0;
                    end else if (run_q == UNLOCK_LAST) begin
                        run_d    = '0;
                        state_d  = S_LOAD_REACQ;
                        beat_d   = 3'd0;
                        relock_d = (relock_q == 4'd15) ? 4'd15 : relock_q + 4'd1;
                    end else begin
                        run_d = run_q + RUN_W'(1);
                    end
                end
                S_LOAD_REACQ: begin
                    if (beat_q == 3'd1) begin
                        state_d = S_ACQUIRE;
                        beat_d  = 3'd0;
                        run_d   = '0;
                    end else begin
                        beat_d = 3'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    beat_d  = 3'd0;
                    run_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so the flops present them in that state's cycle.
    always_comb begin
        clr_d    = (state_d == S_CLEAR);
        busy_d   = (state_d != S_IDLE);
        locked_d = (state_d == S_TRACK);
        pgm_d    = 1'b0;
        sel_d    = 3'd0;
        val_d    = 5'd0;
        case (state_d)
            S_LOAD_ACQ: begin
                pgm_d = 1'b1;
                sel_d = beat_d;
                case (beat_d)
                    3'd0:    val_d = {1'b0, ndiv_q};
                    3'd1:    val_d = aa_q;
                    3'd2:    val_d = ab_q;
                    3'd3:    val_d = off_q;
                    3'd4:    val_d = thr_q;
                    default: val_d = kdco_q;
                endcase
            end
            S_LOAD_TRK: begin
                pgm_d = 1'b1;
                sel_d = (beat_d == 3'd0) ? 3'd1 : 3'd2;
                val_d = (beat_d == 3'd0) ? ta_q : tb_q;
            end
            S_LOAD_REACQ: begin
                pgm_d = 1'b1;
                sel_d = (beat_d == 3'd0) ? 3'd1 : 3'd2;
                val_d = (beat_d == 3'd0) ? aa_q : ab_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            beat_q   <= 3'd0;
            run_q    <= '0;
            relock_q <= 4'd0;
            ndiv_q   <= 4'd0;
            aa_q     <= 5'd0;
            ab_q     <= 5'd0;
            ta_q     <= 5'd0;
            tb_q     <= 5'd0;
            off_q    <= 5'd0;
            thr_q    <= 5'd0;
            kdco_q   <= 5'd0;
            tol_q    <= 5'd0;
            clr_q    <= 1'b0;
            pgm_q    <= 1'b0;
            sel_q    <= 3'd0;
            val_q    <= 5'd0;
            busy_q   <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            run_q    <= run_d;
            relock_q <= relock_d;
            ndiv_q   <= ndiv_d;
            aa_q     <= aa_d;
            ab_q     <= ab_d;
            ta_q     <= ta_d;
            tb_q     <= tb_d;
            off_q    <= off_d;
            thr_q    <= thr_d;
            kdco_q   <= kdco_d;
            tol_q    <= tol_d;
            clr_q    <= clr_d;
            pgm_q    <= pgm_d;
            sel_q    <= sel_d;
            val_q    <= val_d;
            busy_q   <= busy_d;
            locked_q <= locked_d;
        end
    end

    assign pgm_if.clr       = clr_q;
    assign pgm_if.pgm       = pgm_q;
    assign pgm_if.param_sel = sel_q;
    assign pgm_if.pgm_value = val_q;
    assign busy             = busy_q;
    assign locked           = locked_q;
    assign relock_cnt       = relock_q;

endmodule
